// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter shared between two score channels.
//
// One shift engine converts either the current score (ch0) or the high score
// (ch1) to packed BCD. A channel is reconverted whenever its raw input differs
// from the value captured at its last conversion. When both channels are
// dirty, a round-robin bit picks between them.
//
// Ports:
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_score       ch0 binary value
//   i_high_score  ch1 binary value
//   o_score_bcd   ch0 packed BCD, [3:0] = ones digit
//   o_high_bcd    ch1 packed BCD, [3:0] = ones digit
//   o_update      one-cycle pulse, bit n marks the first cycle of a new ch n value
//   o_busy        high while a conversion is in flight (SHIFT or DONE)
module score_bcd_converter #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH-1:0]      i_score,
    input  logic [WIDTH-1:0]      i_high_score,
    output logic [4*DIGITS-1:0]   o_score_bcd,
    output logic [4*DIGITS-1:0]   o_high_bcd,
    output logic [1:0]            o_update,
    output logic                  o_busy
);

    localparam int unsigned BcdW  = 4 * DIGITS;
    localparam int unsigned CntW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned Clamp = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   last0_q, last0_d;
    logic [WIDTH-1:0]   last1_q, last1_d;
    logic               rr_q, rr_d;
    logic               sel_q, sel_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BcdW-1:0]    bcd_q, bcd_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BcdW-1:0]    score_bcd_q, score_bcd_d;
    logic [BcdW-1:0]    high_bcd_q, high_bcd_d;
    logic [1:0]         update_q, update_d;

    logic               dirty0, dirty1;
    logic               pick_hi;
    logic [BcdW-1:0]    adj;

    // Values that cannot be shown in DIGITS digits saturate to all nines.
    function automatic logic [WIDTH-1:0] clamp_val(input logic [WIDTH-1:0] v);
        if (32'(v) > Clamp) begin
            return WIDTH'(Clamp);
        end
        return v;
    endfunction

    // Dirty detection uses the raw input, so a change between two clamped
    // values still triggers a reconversion.
    assign dirty0 = (i_score != last0_q);
    assign dirty1 = (i_high_score != last1_q);

    always_comb begin
        state_d     = state_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        rr_d        = rr_q;
        sel_d       = sel_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        score_bcd_d = score_bcd_q;
        high_bcd_d  = high_bcd_q;
        update_d    = 2'b00;
        pick_hi     = dirty1 && (!dirty0 || rr_q);

        // Add-3 correction; a nibble never exceeds 12 afterwards, so no carry.
        adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (dirty0 || dirty1) begin
                    sel_d = pick_hi;
                    if (pick_hi) begin
                        last1_d = i_high_score;
                        bin_d   = clamp_val(i_high_score);
                    end else begin
                        last0_d = i_score;
                        bin_d   = clamp_val(i_score);
                    end
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = {adj[BcdW-2:0], bin_q[WIDTH-1]};
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (sel_q) begin
                    high_bcd_d = bcd_q;
                    update_d   = 2'b10;
                end else begin
                    score_bcd_d = bcd_q;
                    update_d    = 2'b01;
                end
                rr_d    = ~sel_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            last0_q     <= '0;
            last1_q     <= '0;
            rr_q        <= 1'b0;
            sel_q       <= 1'b0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            score_bcd_q <= '0;
            high_bcd_q  <= '0;
            update_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            rr_q        <= rr_d;
            sel_q       <= sel_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            score_bcd_q <= score_bcd_d;
            high_bcd_q  <= high_bcd_d;
            update_q    <= update_d;
        end
    end

    assign o_score_bcd = score_bcd_q;
    assign o_high_bcd  = high_bcd_q;
    assign o_update    = update_q;
    assign o_busy      = (state_q != StIdle);

endmodule
